// File: rtl/muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// muldiv_seq_if : request/response bundle between the CPU control path and
// the iterative HI/LO multiply/divide sequencer.
//
// Handshake: `start` is a level request. The CPU raises it with op/a/b and
// keeps it high for as long as `stall` is high. The sequencer captures the
// operands on the first enabled edge in IDLE. It raises `done` (== hi_lo_w)
// for exactly one enabled cycle with hi/lo valid. In that cycle `stall` is
// low, so the CPU advances and may drop or re-present `start`. `ena` low
// freezes the sequencer without cancelling the request.
//
// Signals (master = CPU side, slave = sequencer):
//   ena, start, op[1:0], a, b    master -> slave
//   busy, stall, done, hi_lo_w   slave  -> master
//   hi, lo, div_by_zero          slave  -> master
//   state_dbg[2:0]               slave  -> master, FSM state
//                                (0 IDLE, 1 PREP, 2 RUN, 3 FIX, 4 DONE)
// ---------------------------------------------------------------------------
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             ena;
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             stall;
   logic             done;
   logic             hi_lo_w;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;
   logic [2:0]       state_dbg;

   modport master (
      output ena, start, op, a, b,
      input  busy, stall, done, hi_lo_w, hi, lo, div_by_zero, state_dbg
   );

   modport slave (
      input  ena, start, op, a, b,
      output busy, stall, done, hi_lo_w, hi, lo, div_by_zero, state_dbg
   );
endinterface

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq : iterative MUL/MULTU/DIV/DIVU sequencer for the HI/LO path.
// One result bit per cycle: shift-add multiply (LSB first) and restoring
// divide (MSB first) on magnitudes, with sign fix-up afterwards.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   muldiv_seq_if.slave (ena/start/op/a/b in; busy/stall/done/
//         hi_lo_w/hi/lo/div_by_zero/state_dbg out)
//
// Sequence: IDLE -> PREP -> RUN (WIDTH cycles) -> FIX -> DONE -> IDLE.
// ---------------------------------------------------------------------------
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_seq_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t state_q, state_d;

   // captured request
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   // iteration state
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   opnd_q;   // multiplicand (mul) or divisor (div) magnitude
   logic [WIDTH-1:0]   shf_q;    // multiplier shifting right, or dividend/quotient shifting left
   logic [2*WIDTH-1:0] acc_q;    // product accumulator
   logic [WIDTH-1:0]   rem_q;    // partial remainder
   logic               prod_neg_q, quot_neg_q, rem_neg_q, dz_q;

   // results
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             stall_c;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         state_q <= S_IDLE;
      else if (bus.ena) state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      stall_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            // No stall request while reset is held, even with start high.
            stall_c = bus.ena & bus.start & rst;
            if (bus.start) state_d = S_PREP;
         end
         S_PREP: begin
            stall_c = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            stall_c = 1'b1;
            if (cnt_q == '0) state_d = S_FIX;
         end
         S_FIX: begin
            stall_c = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            // start is still high for the finishing instruction; ignore it.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- datapath helpers ----------------
   logic             is_div, is_signed;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_rem_n;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quot_fix, rem_fix, fix_hi, fix_lo;

   always_comb begin
      is_div    = op_q[1];
      is_signed = ~op_q[0];
      // Two's-complement negate of the most negative value wraps back to
      // itself, which is the right unsigned magnitude.
      mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
      mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

      // Multiply step: add multiplicand into the upper half when the current
      // multiplier bit is set, then shift the whole accumulator right.
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{shf_q[0]}}};

      // Divide step: bring down the next dividend bit; the shifted value is
      // one bit wider than the remainder so the trial subtract cannot lose
      // the carry-out.
      div_shift = {rem_q, shf_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      div_rem_n = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];

      prod_fix = prod_neg_q ? -acc_q : acc_q;
      quot_fix = quot_neg_q ? -shf_q : shf_q;
      rem_fix  = rem_neg_q  ? -rem_q : rem_q;

      if (!is_div) begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end else if (dz_q) begin
         fix_hi = a_q;
         fix_lo = '1;
      end else begin
         fix_hi = rem_fix;
         fix_lo = quot_fix;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         cnt_q      <= '0;
         opnd_q     <= '0;
         shf_q      <= '0;
         acc_q      <= '0;
         rem_q      <= '0;
         prod_neg_q <= 1'b0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else if (bus.ena) begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  op_q <= bus.op;
                  a_q  <= bus.a;
                  b_q  <= bus.b;
               end
            end
            S_PREP: begin
               opnd_q     <= is_div ? mag_b : mag_a;
               shf_q      <= is_div ? mag_a : mag_b;
               prod_neg_q <= (op_q == 2'b00) & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               quot_neg_q <= (op_q == 2'b10) & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               rem_neg_q  <= (op_q == 2'b10) & a_q[WIDTH-1];
               dz_q       <= is_div & (b_q == '0);
               acc_q      <= '0;
               rem_q      <= '0;
               cnt_q      <= CW'(WIDTH - 1);
            end
            S_RUN: begin
               cnt_q <= cnt_q - 1'b1;
               if (!is_div) begin
                  acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                  shf_q <= shf_q >> 1;
               end else begin
                  rem_q <= div_rem_n;
                  shf_q <= {shf_q[WIDTH-2:0], div_ge};
               end
            end
            S_FIX: begin
               hi_q <= fix_hi;
               lo_q <= fix_lo;
            end
            default: ;
         endcase
      end
   end

   // ---------------- outputs ----------------
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.stall       = stall_c;
   assign bus.done        = (state_q == S_DONE);
   assign bus.hi_lo_w     = (state_q == S_DONE);
   assign bus.div_by_zero = (state_q == S_DONE) & dz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.state_dbg   = state_q;

endmodule
